rom_download_ctrl: RTL

ROM_DOWNLOAD_CTRL -- requirements
Module: rom_download_ctrl

---
 rtl/rom_download_ctrl_pkg.sv | 24 ++
 rtl/dl_hold_timer.sv | 36 +++
 rtl/rom_download_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/rom_download_ctrl_pkg.sv
// Shared types and default constants for the ROM download controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rom_download_ctrl_pkg;

  // Default parameter values for the download controller.
  localparam logic [7:0] DEF_ROM_INDEX   = 8'd0;
  localparam int         DEF_ADDR_W      = 14;
  localparam int         DEF_HOLD_CYCLES = 16;

  // State encodings, kept as plain constants for older code that matches on raw values.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACTIVE = ST_ACTIVE,
    WRITE  = ST_WRITE,
    HOLD   = ST_HOLD
  } dl_state_t;

endpackage

// File: rtl/dl_hold_timer.sv
// Counts the post-download reset hold window; expired marks its last cycle.
// Latency: expired rises on the HOLD_CYCLES-th tick after start drops.
// Backpressure: none; start has priority and clears the count.
// Ports: clk/reset_n; start clears the count; tick advances it; expired is
// high while the count sits at HOLD_CYCLES-1 (the final cycle of the window).
module dl_hold_timer
  import rom_download_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic tick,
  output logic expired
);

  localparam int               CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  assign expired = (cnt_q == LAST);

  // The count parks at LAST, so it can never wrap if the owner lingers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (tick && !expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rom_download_ctrl.sv
// Bridges host ioctl byte downloads into core memory writes and sequences core reset.
// Latency: dn_wr rises the cycle after an accepted ioctl_wr strobe.
// Backpressure: ioctl_wait mirrors dn_wr and holds until mem_ready accepts the write.
// Ports: ioctl_* is the host download side; dn_addr/dn_data/dn_wr with mem_ready is
// the core write side; core_reset, dl_done (pulse), dl_error (sticky) and
// byte_count report session status.
module rom_download_ctrl
  import rom_download_ctrl_pkg::*;
#(
  parameter logic [7:0] ROM_INDEX   = DEF_ROM_INDEX,
  parameter int         ADDR_W      = DEF_ADDR_W,
  parameter int         HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic              core_reset,
  output logic              dl_done,
  output logic              dl_error,
  output logic [ADDR_W:0]   byte_count
);

  localparam logic [ADDR_W:0] BC_MAX = '1;

  dl_state_t state_q;
  logic      start_match;
  logic      addr_ok;
  logic      hold_expired;

  assign start_match = ioctl_download && (ioctl_index == ROM_INDEX);
  // In range when nothing above the core address width is set.
  assign addr_ok     = (ioctl_addr[24:ADDR_W] == '0);

  // Outputs decoded from state so an async reset clears them immediately.
  assign dn_wr      = (state_q == WRITE);
  assign ioctl_wait = (state_q == WRITE);
  assign core_reset = (state_q != IDLE);

  // The timer is held clear outside HOLD, so re-entering HOLD always restarts it.
  dl_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (state_q != HOLD),
    .tick   (state_q == HOLD),
    .expired(hold_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dn_addr    <= '0;
      dn_data    <= '0;
      dl_done    <= 1'b0;
      dl_error   <= 1'b0;
      byte_count <= '0;
    end else begin
      dl_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_match) begin
            state_q    <= ACTIVE;
            byte_count <= '0;
            dl_error   <= 1'b0;
          end
        end
        ACTIVE: begin
          if (ioctl_wr && addr_ok) begin
            dn_addr <= ioctl_addr[ADDR_W-1:0];
            dn_data <= ioctl_dout;
            state_q <= WRITE;
          end else begin
            // An out-of-range byte is dropped; a session end in the same cycle still closes it.
            if (ioctl_wr) dl_error <= 1'b1;
            if (!ioctl_download) state_q <= HOLD;
          end
        end
        WRITE: begin
          // Host strobed while stalled: flag it, keep the pending write intact.
          if (ioctl_wr) dl_error <= 1'b1;
          if (mem_ready) begin
            if (byte_count != BC_MAX) byte_count <= byte_count + (ADDR_W+1)'(1);
            state_q <= ioctl_download ? ACTIVE : HOLD;
          end
        end
        HOLD: begin
          if (start_match) begin
            state_q    <= ACTIVE;
            byte_count <= '0;
            dl_error   <= 1'b0;
          end else if (hold_expired) begin
            state_q <= IDLE;
            dl_done <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
